// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file.
// master: decode/writeback side (drives writes, read addresses, issue marks)
// slave : register file (returns read data and busy flags)
// Signals:
//   RegWEn    per-port write enable            [NWR]
//   rsw       per-port write address           [NWR*AW]
//   data_in   per-port write data              [NWR*XLEN]
//   rs        per-port read address            [NRD*AW]
//   data_out  per-port read data               [NRD*XLEN]
//   busy_set  mark busy_addr as pending
//   busy_addr destination register being issued [AW]
//   rd_busy   per-port pending flag            [NRD]
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]      RegWEn;
    logic [NWR*AW-1:0]   rsw;
    logic [NWR*XLEN-1:0] data_in;
    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] data_out;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic [NRD-1:0]      rd_busy;

    modport master (
        output RegWEn, rsw, data_in, rs, busy_set, busy_addr,
        input  data_out, rd_busy
    );

    modport slave (
        input  RegWEn, rsw, data_in, rs, busy_set, busy_addr,
        output data_out, rd_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for hazard detection.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  reg_file_mp_if.slave (write ports, read ports, scoreboard)
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] NREGS_LIM = (AW+1)'(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [AW-1:0]   w_waddr [NWR];
    logic [XLEN-1:0] w_wdata [NWR];
    logic [NWR-1:0]  w_wr_ok;
    logic            w_set_ok;

    logic [AW-1:0]   w_raddr [NRD];
    logic            w_rd_ok [NRD];
    logic            w_hit   [NRD];
    logic [XLEN-1:0] w_rdata [NRD];
    logic [NRD-1:0]  w_rbusy;

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_LIM) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        for (int i = 0; i < NWR; i++) begin
            w_waddr[i] = bus.rsw[i*AW +: AW];
            w_wdata[i] = bus.data_in[i*XLEN +: XLEN];
            w_wr_ok[i] = bus.RegWEn[i] && addr_ok(w_waddr[i]);
        end
    end

    always_comb begin
        w_set_ok = bus.busy_set && addr_ok(bus.busy_addr);
    end

    // Ports are applied in ascending order so the highest-index writer wins;
    // the issue mark is applied last so a new producer outranks a retiring one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (w_wr_ok[i]) begin
                    r_regs[w_waddr[i]] <= w_wdata[i];
                    r_busy[w_waddr[i]] <= 1'b0;
                end
            end
            if (w_set_ok) begin
                r_busy[bus.busy_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            w_raddr[j] = bus.rs[j*AW +: AW];
            w_rd_ok[j] = addr_ok(w_raddr[j]);
            w_rdata[j] = w_rd_ok[j] ? r_regs[w_raddr[j]] : '0;
            w_rbusy[j] = w_rd_ok[j] && r_busy[w_raddr[j]];
            w_hit[j]   = 1'b0;
            if (BYPASS) begin
                for (int i = 0; i < NWR; i++) begin
                    if (w_wr_ok[i] && (w_waddr[i] == w_raddr[j])) begin
                        w_rdata[j] = w_wdata[i];
                        w_hit[j]   = 1'b1;
                    end
                end
            end
            // A retiring write clears the hazard unless it is being re-issued now.
            if (w_hit[j] && !(w_set_ok && (bus.busy_addr == w_raddr[j]))) begin
                w_rbusy[j] = 1'b0;
            end
            if (!rst) begin
                w_rdata[j] = '0;
                w_rbusy[j] = 1'b0;
            end
        end
    end

    always_comb begin
        bus.data_out = '0;
        for (int j = 0; j < NRD; j++) begin
            bus.data_out[j*XLEN +: XLEN] = w_rdata[j];
        end
    end

    assign bus.rd_busy = w_rbusy;
endmodule
